// File: rtl/uart_tx.sv
// Serial 8N1 UART transmitter with valid/ready byte input and registered outputs.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 2605
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_serial,
   output logic       tx_done
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

   state_e          state_q, state_d;
   logic [7:0]      shift_q, shift_d;
   logic [2:0]      bit_q, bit_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            serial_d, ready_d, done_d;
   logic            bit_end;
`ifdef UART_TX_PARITY_EN
   logic            parity_q, parity_d;
`endif

   assign bit_end = (cnt_q == CntMax);

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      cnt_d    = bit_end ? '0 : cnt_q + CntW'(1);
      serial_d = tx_serial;
      ready_d  = tx_ready;
      done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      unique case (state_q)
         StIdle: begin
            cnt_d    = '0;
            serial_d = 1'b1;
            // tx_ready is registered, so the first idle cycle after reset never accepts
            if (tx_ready && tx_valid) begin
               shift_d  = tx_data;
               bit_d    = '0;
               serial_d = 1'b0;
               ready_d  = 1'b0;
               state_d  = StStart;
`ifdef UART_TX_PARITY_EN
               parity_d = ^tx_data;
`endif
            end else begin
               ready_d = 1'b1;
            end
         end
         StStart: begin
            if (bit_end) begin
               serial_d = shift_q[0];
               shift_d  = shift_q >> 1;
               bit_d    = '0;
               state_d  = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  serial_d = parity_q;
                  state_d  = StParity;
`else
                  serial_d = 1'b1;
                  state_d  = StStop;
`endif
               end else begin
                  serial_d = shift_q[0];
                  shift_d  = shift_q >> 1;
                  bit_d    = bit_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bit_end) begin
               serial_d = 1'b1;
               state_d  = StStop;
            end
         end
`endif
         StStop: begin
            if (bit_end) begin
               serial_d = 1'b1;
               ready_d  = 1'b1;
               done_d   = 1'b1;
               state_d  = StIdle;
            end
         end
         default: begin
            serial_d = 1'b1;
            state_d  = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         bit_q     <= '0;
         cnt_q     <= '0;
         tx_serial <= 1'b1;
         tx_ready  <= 1'b0;
         tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_q     <= bit_d;
         cnt_q     <= cnt_d;
         tx_serial <= serial_d;
         tx_ready  <= ready_d;
         tx_done   <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-index model checked every cycle plus literal frame expectations.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx;

   localparam int unsigned C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB        = 11;
   localparam int FRAME_LIT = 44;
   int exp_a5 [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
   localparam int NB        = 10;
   localparam int FRAME_LIT = 40;
   int exp_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
   localparam int FRAME = NB * C;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b1;
   logic       tx_ready, tx_serial, tx_done;

   uart_tx #(.CLKS_PER_BIT(C)) dut (
      .clock    (clock),
      .reset    (reset),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_serial(tx_serial),
      .tx_done  (tx_done)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   int total = 0;
   int passed = 0;
   int done_cnt = 0;

   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Model: position t within the frame selects start / data[i] / parity / stop.
   bit         m_busy = 1'b0;
   bit         m_ready = 1'b0;
   bit         m_done = 1'b0;
   int         m_t = 0;
   logic [7:0] m_byte = 8'h00;

   function automatic logic line_at(input logic [7:0] b, input int t);
      int idx;
      idx = t / C;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_busy = 1'b0; m_ready = 1'b0; m_done = 1'b0;
      end else if (!m_busy) begin
         m_done = 1'b0;
         if (m_ready && tx_valid) begin
            m_busy = 1'b1; m_t = 0; m_byte = tx_data; m_ready = 1'b0;
         end else begin
            m_ready = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         m_t++;
         if (m_t == FRAME) begin
            m_busy = 1'b0; m_ready = 1'b1; m_done = 1'b1;
         end
      end
   end

   always @(negedge clock) begin
      check("model_serial", {31'd0, tx_serial}, {31'd0, m_busy ? line_at(m_byte, m_t) : 1'b1});
      check("model_ready", {31'd0, tx_ready}, {31'd0, m_ready});
      check("model_done", {31'd0, tx_done}, {31'd0, m_done});
      if (tx_done === 1'b1) done_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send(input logic [7:0] b, output int a0);
      tx_data  = b;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      a0 = cyc;
   endtask

   task automatic wait_done(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         if (tx_done === 1'b1) begin
            at = cyc;
            break;
         end
         tick(1);
      end
      total++;
      if (at >= 0) passed++;
      else $display("FAIL done_timeout: got no tx_done, expected one within %0d cycles", limit);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int a0, at, dn0, k;

      // reset held with tx_valid high
      reset = 1'b1; tx_valid = 1'b1; tx_data = 8'h55;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("rst_ready", {31'd0, tx_ready}, 32'd0);
         check("rst_serial", {31'd0, tx_serial}, 32'd1);
         check("rst_done", {31'd0, tx_done}, 32'd0);
      end
      reset = 1'b0; tx_valid = 1'b0;
      tick(1);
      check("ready_after_rst", {31'd0, tx_ready}, 32'd1);

      // single byte 0xA5, sampled one cycle into each bit
      dn0 = done_cnt;
      send(8'hA5, a0);
      k = 0;
      for (int i = 0; i < NB; i++) begin
         tick(4 * i + 1 - k);
         k = 4 * i + 1;
         check($sformatf("a5_bit%0d", i), {31'd0, tx_serial}, exp_a5[i]);
      end
      wait_done(20, at);
      check("a5_frame_len", at - a0, FRAME_LIT);
      tick(3);
      check("a5_done_once", done_cnt - dn0, 32'd1);

      // back-to-back 0x00 then 0xFF with tx_valid held; data changes mid-frame
      tx_data = 8'h00; tx_valid = 1'b1;
      tick(1);
      a0 = cyc;
      tx_data = 8'hFF;
      wait_done(FRAME + 10, at);
      check("b2b_len1", at - a0, FRAME_LIT);
      check("b2b_gap_serial", {31'd0, tx_serial}, 32'd1);
      check("b2b_gap_ready", {31'd0, tx_ready}, 32'd1);
      tick(1);
      check("b2b_start2", {31'd0, tx_serial}, 32'd0);
      check("b2b_ready2_low", {31'd0, tx_ready}, 32'd0);
      tx_valid = 1'b0;
      wait_done(FRAME + 10, at);
      check("b2b_len2", at - a0, 2 * FRAME_LIT + 1);

      // reset in the middle of a 0x3C frame
      tick(2);
      dn0 = done_cnt;
      send(8'h3C, a0);
      tick(14);
      reset = 1'b1;
      tick(1);
      check("midrst_serial", {31'd0, tx_serial}, 32'd1);
      check("midrst_ready", {31'd0, tx_ready}, 32'd0);
      reset = 1'b0;
      tick(1);
      check("midrst_ready_back", {31'd0, tx_ready}, 32'd1);
      tick(FRAME);
      check("midrst_no_done", done_cnt - dn0, 32'd0);
      send(8'h81, a0);
      wait_done(FRAME + 10, at);
      check("after_rst_len", at - a0, FRAME_LIT);

      // tx_valid raised mid-DATA and dropped before idle must be ignored
      tick(2);
      dn0 = done_cnt;
      send(8'h5A, a0);
      tick(12);
      tx_valid = 1'b1; tx_data = 8'hC3;
      tick(20);
      tx_valid = 1'b0;
      wait_done(20, at);
      check("busy_len", at - a0, FRAME_LIT);
      tick(FRAME);
      check("busy_no_second", done_cnt - dn0, 32'd1);
      check("busy_idle_serial", {31'd0, tx_serial}, 32'd1);

`ifdef UART_TX_PARITY_EN
      // 0x07 has odd weight, so even parity bit is 1
      send(8'h07, a0);
      tick(37);
      check("parity_07", {31'd0, tx_serial}, 32'd1);
      wait_done(20, at);
      check("parity_07_len", at - a0, 32'd44);
`endif

      tick(2);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
